// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick timer: FSM state encoding and parameter defaults.
package tick_timer_pkg;

    localparam int unsigned PRESCALE_M_DEF = 10;
    localparam int unsigned PRE_N_DEF      = 4;
    localparam int unsigned CNT_W_DEF      = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/tick_timer_ctrl_if.sv
// Control/status bundle between a requester and the tick timer controller.
interface tick_timer_ctrl_if
    import tick_timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] count_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;
    logic             unit_tick;

    modport master (
        output start,
        output abort,
        output count_in,
        input  busy,
        input  done,
        input  remaining,
        input  unit_tick
    );

    modport slave (
        input  start,
        input  abort,
        input  count_in,
        output busy,
        output done,
        output remaining,
        output unit_tick
    );

endinterface

// File: rtl/tick_prescaler.sv
// Mod-PRESCALE_M counter with synchronous clear (priority over enable) and terminal-count flag.
module tick_prescaler
    import tick_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_M = PRESCALE_M_DEF,
    parameter int unsigned PRE_N      = PRE_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [PRE_N-1:0] o_count,
    output logic             o_max_tick
);

    localparam logic [PRE_N-1:0] MaxVal = PRE_N'(PRESCALE_M - 1);

    logic [PRE_N-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == MaxVal) ? '0 : r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_max_tick = (r_count == MaxVal);

endmodule

// File: rtl/tick_timer_ctrl.sv
// Tick timer controller: runs for count_in prescaled units, with abort and a one-cycle done pulse.
module tick_timer_ctrl
    import tick_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_M = PRESCALE_M_DEF,
    parameter int unsigned PRE_N      = PRE_N_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    tick_timer_ctrl_if.slave bus
);

    state_t           r_state;
    logic [CNT_W-1:0] r_remaining;
    logic             r_busy;
    logic             r_done;

    logic [PRE_N-1:0] w_pre_count;
    logic             w_pre_max;
    logic             w_pre_clr;
    logic             w_pre_en;
    logic             w_unit_tick;

    // Clearing on abort keeps the prescaler at 0 in the IDLE cycle that follows.
    assign w_pre_en    = r_busy;
    assign w_pre_clr   = !r_busy || bus.abort;
    assign w_unit_tick = r_busy && w_pre_max;

    tick_prescaler #(
        .PRESCALE_M (PRESCALE_M),
        .PRE_N      (PRE_N)
    ) u_prescaler (
        .clk        (clk),
        .rst        (reset),
        .i_clr      (w_pre_clr),
        .i_en       (w_pre_en),
        .o_count    (w_pre_count),
        .o_max_tick (w_pre_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.count_in != '0) begin
                            r_remaining <= bus.count_in;
                            r_busy      <= 1'b1;
                            r_state     <= StRun;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                end
                StRun: begin
                    if (bus.abort) begin
                        r_remaining <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end else if (w_unit_tick) begin
                        if (r_remaining <= CNT_W'(1)) begin
                            r_remaining <= '0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= StDone;
                        end else begin
                            r_remaining <= r_remaining - 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.remaining = r_remaining;
    assign bus.unit_tick = w_unit_tick;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Scoreboard bench for tick_timer_ctrl: expected tick/done events queued, monitor compares.
module tb_tick_timer_ctrl;

    import tick_timer_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    tick_timer_ctrl_if #(.CNT_W(8)) bus ();

    tick_timer_ctrl #(
        .PRESCALE_M (10),
        .PRE_N      (4),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int base     = 0;
    int checks   = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic       is_done;
        logic [7:0] rem;
    } ev_t;

    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d rel %0d)", name, act, exp, cyc,
                     cyc - base);
        end
    endtask

    task automatic push(input int c, input logic d, input logic [7:0] r);
        ev_t e;
        e.cyc     = c;
        e.is_done = d;
        e.rem     = r;
        exp_q.push_back(e);
    endtask

    // Monitor: every tick or done pulse must match the head of the queue.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (bus.unit_tick || bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got tick=%0d done=%0d at rel cycle %0d, expected none",
                         bus.unit_tick, bus.done, cyc - base);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", 32'(cyc - base), 32'(e.cyc));
                check("event_done", {31'd0, bus.done}, {31'd0, e.is_done});
                check("event_tick", {31'd0, bus.unit_tick}, {31'd0, !e.is_done});
                check("event_remaining", {24'd0, bus.remaining}, {24'd0, e.rem});
                check("event_busy", {31'd0, bus.busy}, {31'd0, !e.is_done});
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            next_cycle();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (4) next_cycle();
    endtask

    task automatic launch(input logic [7:0] c);
        base         = cyc;
        bus.start    = 1'b1;
        bus.count_in = c;
        next_cycle();
        bus.start    = 1'b0;
        bus.count_in = 8'hA5;
    endtask

    task automatic run_nominal(input string tag);
        push(10, 1'b0, 8'd3);
        push(20, 1'b0, 8'd2);
        push(30, 1'b0, 8'd1);
        push(31, 1'b1, 8'd0);
        launch(8'd3);
        check({tag, "_busy_c1"}, {31'd0, bus.busy}, 32'd1);
        check({tag, "_rem_c1"}, {24'd0, bus.remaining}, 32'd3);
        goto_cycle(base + 30);
        check({tag, "_busy_c30"}, {31'd0, bus.busy}, 32'd1);
        next_cycle();
        check({tag, "_busy_c31"}, {31'd0, bus.busy}, 32'd0);
        drain({tag, "_drain"}, 100);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.count_in = 8'd0;
        reset        = 1'b1;
        #2;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_remaining", {24'd0, bus.remaining}, 32'd0);
        check("reset_tick", {31'd0, bus.unit_tick}, 32'd0);
        next_cycle();
        reset = 1'b0;

        // Nominal run accepted on the first edge after reset release.
        run_nominal("nominal");

        // Zero count: done next cycle, never busy.
        push(1, 1'b1, 8'd0);
        launch(8'd0);
        check("zero_busy_c1", {31'd0, bus.busy}, 32'd0);
        check("zero_rem_c1", {24'd0, bus.remaining}, 32'd0);
        drain("zero_drain", 20);

        // Abort coinciding with the final tick.
        push(10, 1'b0, 8'd2);
        push(20, 1'b0, 8'd1);
        launch(8'd2);
        goto_cycle(base + 20);
        bus.abort = 1'b1;
        next_cycle();
        bus.abort = 1'b0;
        check("abort_busy_c21", {31'd0, bus.busy}, 32'd0);
        check("abort_rem_c21", {24'd0, bus.remaining}, 32'd0);
        check("abort_done_c21", {31'd0, bus.done}, 32'd0);
        drain("abort_drain", 20);

        // Start during RUN must not reload or disturb the prescaler.
        for (int i = 0; i < 5; i++) push(10 * (i + 1), 1'b0, 8'(5 - i));
        push(51, 1'b1, 8'd0);
        launch(8'd5);
        goto_cycle(base + 4);
        bus.start    = 1'b1;
        bus.count_in = 8'd9;
        next_cycle();
        bus.start    = 1'b0;
        check("ignore_rem_c5", {24'd0, bus.remaining}, 32'd5);
        drain("ignore_drain", 100);

        // Asynchronous reset mid-run.
        push(10, 1'b0, 8'd4);
        launch(8'd4);
        goto_cycle(base + 15);
        #1;
        check("midrun_busy_pre", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrun_busy", {31'd0, bus.busy}, 32'd0);
        check("midrun_done", {31'd0, bus.done}, 32'd0);
        check("midrun_remaining", {24'd0, bus.remaining}, 32'd0);
        check("midrun_tick", {31'd0, bus.unit_tick}, 32'd0);
        next_cycle();
        check("midrun_queue", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        run_nominal("after_reset");

        // Start held high: back-to-back single-unit runs.
        push(10, 1'b0, 8'd1);
        push(11, 1'b1, 8'd0);
        push(22, 1'b0, 8'd1);
        push(23, 1'b1, 8'd0);
        push(34, 1'b0, 8'd1);
        push(35, 1'b1, 8'd0);
        base         = cyc;
        bus.start    = 1'b1;
        bus.count_in = 8'd1;
        goto_cycle(base + 35);
        bus.start = 1'b0;
        drain("b2b_drain", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
